// File: rtl/enigma_ascii_out.sv
// Enigma 6-bit code to ASCII converter: two-stage registered mapping feeding
// an output FIFO with ready/valid handshake, character counter and sticky overflow.
module enigma_ascii_out #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [5:0]       code_in,
   input  logic             code_valid,
   input  logic             clr,
   output logic [7:0]       ascii_out,
   output logic             ascii_valid,
   input  logic             ascii_ready,
   output logic [CNT_W-1:0] char_cnt,
   output logic             fifo_full,
   output logic             overflow
);

   // state      | meaning
   // ST_EMPTY   | occupancy == 0, nothing to present
   // ST_PARTIAL | 0 < occupancy < DEPTH
   // ST_FULL    | occupancy == DEPTH, pushes dropped unless popping
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   function automatic logic [7:0] map_code(input logic [5:0] c);
      logic [7:0] c8;
      c8 = {2'b00, c};
      if (c8 < 8'd26)      return 8'h61 + c8;
      else if (c8 < 8'd52) return 8'h41 + (c8 - 8'd26);
      else if (c8 < 8'd62) return 8'h30 + (c8 - 8'd52);
      else if (c8 == 8'd62) return 8'h20;
      else                 return 8'h0A;
   endfunction

   logic [5:0]       code_q;
   logic             vld_q;
   logic [7:0]       byte_q;
   logic             bvld_q;
   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      occ_q, occ_d;
   logic [1:0]       state_q, state_d;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pop, wr_en, drop, flush;

   assign flush       = srst | clr;
   assign ascii_valid = (state_q != ST_EMPTY);
   assign fifo_full   = (state_q == ST_FULL);
   assign ascii_out   = ascii_valid ? mem_q[rd_q] : 8'h00;
   assign char_cnt    = cnt_q;
   assign overflow    = ovf_q;

   always_comb begin
      pop   = ascii_valid & ascii_ready;
      wr_en = bvld_q & ((state_q != ST_FULL) | pop);
      drop  = bvld_q & (state_q == ST_FULL) & ~pop;
      occ_d = occ_q;
      if (wr_en && !pop)      occ_d = occ_q + 1'b1;
      else if (!wr_en && pop) occ_d = occ_q - 1'b1;
      state_d = ST_PARTIAL;
      if (occ_d == '0)            state_d = ST_EMPTY;
      else if (occ_d == FULL_CNT) state_d = ST_FULL;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         code_q  <= '0;
         vld_q   <= 1'b0;
         byte_q  <= '0;
         bvld_q  <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         occ_q   <= '0;
         state_q <= ST_EMPTY;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         code_q  <= code_in;
         vld_q   <= code_valid;
         byte_q  <= map_code(code_q);
         bvld_q  <= vld_q;
         occ_q   <= occ_d;
         state_q <= state_d;
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
         if (drop)  ovf_q <= 1'b1;
         // Dropped codes still count; counter sticks at all-ones.
         if (vld_q && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && wr_en) mem_q[wr_q] <= byte_q;
   end

endmodule

// File: tb/tb_enigma_ascii_out.sv
// Directed bench for enigma_ascii_out: mapping, latency, backpressure,
// full push/pop, clr/srst flushing and a randomised-handshake stream.
module tb_enigma_ascii_out;

   logic        clk = 1'b0;
   logic        srst = 1'b0;
   logic [5:0]  code_in = '0;
   logic        code_valid = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  ascii_out;
   logic        ascii_valid;
   logic        ascii_ready = 1'b0;
   logic [16:0] char_cnt;
   logic        fifo_full;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   string alph;

   enigma_ascii_out #(.DEPTH(8), .CNT_W(17)) dut (
      .clk(clk), .srst(srst), .code_in(code_in), .code_valid(code_valid),
      .clr(clr), .ascii_out(ascii_out), .ascii_valid(ascii_valid),
      .ascii_ready(ascii_ready), .char_cnt(char_cnt), .fifo_full(fifo_full),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      code_valid = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   task automatic push_codes(input logic [5:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         code_in = first + 6'(i);
         code_valid = 1'b1;
         tick();
      end
      code_valid = 1'b0;
   endtask

   task automatic test_reset();
      srst = 1'b1; code_valid = 1'b1; code_in = 6'h05; ascii_ready = 1'b0;
      tick(); tick();
      srst = 1'b0; code_valid = 1'b0;
      checks++; if (ascii_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", ascii_out); end
      checks++; if (ascii_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ascii_valid); end
      checks++; if (char_cnt !== 17'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", char_cnt); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      tick(); tick(); tick();
      checks++; if (ascii_valid !== 1'b0 || char_cnt !== 17'd0) begin errors++; $display("FAIL reset_discard got v=%b cnt=%0d exp v=0 cnt=0", ascii_valid, char_cnt); end
   endtask

   task automatic test_latency();
      ascii_ready = 1'b1;
      code_in = 6'h07; code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
      checks++; if (ascii_valid !== 1'b0) begin errors++; $display("FAIL lat_n got %b exp 0", ascii_valid); end
      tick();
      checks++; if (ascii_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b exp 0", ascii_valid); end
      tick();
      checks++; if (ascii_valid !== 1'b1 || ascii_out !== 8'h68) begin errors++; $display("FAIL lat_n2 got v=%b %h exp v=1 68", ascii_valid, ascii_out); end
      tick();
      checks++; if (ascii_valid !== 1'b0 || char_cnt !== 17'd1) begin errors++; $display("FAIL lat_pop got v=%b cnt=%0d exp v=0 cnt=1", ascii_valid, char_cnt); end
   endtask

   task automatic test_mapping_sweep();
      int got = 0;
      do_clr();
      ascii_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         code_valid = (i < 64);
         code_in = 6'(i);
         tick();
         if (ascii_valid) begin
            checks++;
            if (got >= 64 || ascii_out !== alph[got]) begin
               errors++; $display("FAIL sweep_byte idx %0d got %h exp %h", got, ascii_out, (got < 64) ? alph[got] : 8'hxx);
            end
            got++;
         end
      end
      code_valid = 1'b0;
      checks++; if (got != 64) begin errors++; $display("FAIL sweep_count got %0d exp 64", got); end
      checks++; if (char_cnt !== 17'd64) begin errors++; $display("FAIL sweep_cnt got %0d exp 64", char_cnt); end
   endtask

   task automatic test_backpressure();
      int got = 0;
      do_clr();
      ascii_ready = 1'b0;
      push_codes(6'h10, 8);
      tick(); tick(); tick();
      checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL bp_full got full=%b ovf=%b exp 1 0", fifo_full, overflow); end
      checks++; if (char_cnt !== 17'd8) begin errors++; $display("FAIL bp_cnt8 got %0d exp 8", char_cnt); end
      push_codes(6'h3E, 1);
      tick(); tick(); tick();
      checks++; if (overflow !== 1'b1 || char_cnt !== 17'd9) begin errors++; $display("FAIL bp_ovf got ovf=%b cnt=%0d exp 1 9", overflow, char_cnt); end
      checks++; if (ascii_out !== 8'h71) begin errors++; $display("FAIL bp_stable got %h exp 71", ascii_out); end
      ascii_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (ascii_valid) begin
            checks++;
            if (got >= 8 || ascii_out !== 8'h71 + 8'(got)) begin errors++; $display("FAIL bp_drain idx %0d got %h exp %h", got, ascii_out, 8'h71 + 8'(got)); end
            got++;
         end
         tick();
      end
      checks++; if (got != 8) begin errors++; $display("FAIL bp_drain_count got %0d exp 8", got); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b exp 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      int got = 0;
      do_clr();
      ascii_ready = 1'b0;
      push_codes(6'h1A, 8);
      tick(); tick(); tick();
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", fifo_full); end
      code_in = 6'h22; code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
      tick();
      ascii_ready = 1'b1;
      tick();
      ascii_ready = 1'b0;
      checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_state got full=%b ovf=%b exp 1 0", fifo_full, overflow); end
      checks++; if (ascii_out !== 8'h42 || char_cnt !== 17'd9) begin errors++; $display("FAIL fpp_head got %h cnt=%0d exp 42 cnt=9", ascii_out, char_cnt); end
      ascii_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (ascii_valid) begin
            checks++;
            if (got >= 8 || ascii_out !== 8'h42 + 8'(got)) begin errors++; $display("FAIL fpp_drain idx %0d got %h exp %h", got, ascii_out, 8'h42 + 8'(got)); end
            got++;
         end
         tick();
      end
      checks++; if (got != 8) begin errors++; $display("FAIL fpp_drain_count got %0d exp 8", got); end
   endtask

   task automatic test_clr();
      do_clr();
      ascii_ready = 1'b0;
      push_codes(6'h00, 9);
      tick(); tick(); tick();
      ascii_ready = 1'b1;
      tick(); tick(); tick();
      ascii_ready = 1'b0;
      checks++; if (overflow !== 1'b1 || ascii_out !== 8'h64) begin errors++; $display("FAIL clr_pre got ovf=%b %h exp 1 64", overflow, ascii_out); end
      clr = 1'b1; code_valid = 1'b1; code_in = 6'h05;
      tick();
      clr = 1'b0; code_valid = 1'b0;
      checks++; if (ascii_valid !== 1'b0 || char_cnt !== 17'd0 || overflow !== 1'b0 || fifo_full !== 1'b0)
         begin errors++; $display("FAIL clr_state got v=%b cnt=%0d ovf=%b full=%b exp 0 0 0 0", ascii_valid, char_cnt, overflow, fifo_full); end
      tick(); tick(); tick();
      checks++; if (ascii_valid !== 1'b0 || char_cnt !== 17'd0) begin errors++; $display("FAIL clr_discard got v=%b cnt=%0d exp 0 0", ascii_valid, char_cnt); end
      ascii_ready = 1'b1;
      code_in = 6'h00; code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
      tick(); tick();
      checks++; if (ascii_valid !== 1'b1 || ascii_out !== 8'h61) begin errors++; $display("FAIL clr_fresh got v=%b %h exp 1 61", ascii_valid, ascii_out); end
      tick();
   endtask

   task automatic test_srst_midstream();
      ascii_ready = 1'b0;
      push_codes(6'h30, 3);
      srst = 1'b1; clr = 1'b1; code_valid = 1'b1; code_in = 6'h01;
      tick();
      srst = 1'b0; clr = 1'b0; code_valid = 1'b0;
      tick(); tick(); tick();
      checks++; if (ascii_valid !== 1'b0 || char_cnt !== 17'd0 || ascii_out !== 8'h00) begin errors++; $display("FAIL srst_mid got v=%b cnt=%0d out=%h exp 0 0 00", ascii_valid, char_cnt, ascii_out); end
      code_in = 6'h3F; code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
      tick(); tick();
      checks++; if (ascii_out !== 8'h0A || char_cnt !== 17'd1) begin errors++; $display("FAIL srst_fresh got %h cnt=%0d exp 0a 1", ascii_out, char_cnt); end
      ascii_ready = 1'b1;
      tick();
   endtask

   task automatic test_long_stream();
      localparam int N_LONG = 2500;
      logic [7:0] exp_q [$];
      logic [7:0] e;
      int sent = 0;
      int cyc = 0;
      do_clr();
      while (sent < N_LONG && cyc < 20 * N_LONG) begin
         ascii_ready = fifo_full ? 1'b1 : ($urandom_range(3) != 0);
         if (ascii_valid && ascii_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL long_extra got %h exp none", ascii_out); end
            else begin
               e = exp_q.pop_front();
               if (ascii_out !== e) begin errors++; $display("FAIL long_byte got %h exp %h", ascii_out, e); end
            end
         end
         code_valid = ($urandom_range(1) == 1);
         code_in = 6'($urandom_range(63));
         if (code_valid) begin
            exp_q.push_back(alph[int'(code_in)]);
            sent++;
         end
         tick();
         cyc++;
      end
      code_valid = 1'b0;
      ascii_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (ascii_valid) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL long_extra got %h exp none", ascii_out); end
            else begin
               e = exp_q.pop_front();
               if (ascii_out !== e) begin errors++; $display("FAIL long_byte got %h exp %h", ascii_out, e); end
            end
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL long_left got %0d exp 0", exp_q.size()); end
      checks++; if (char_cnt !== 17'(N_LONG) || overflow !== 1'b0) begin errors++; $display("FAIL long_cnt got %0d ovf=%b exp %0d 0", char_cnt, overflow, N_LONG); end
   endtask

   initial begin
      alph = {"abcdefghijklmnopqrstuvwxyz", "ABCDEFGHIJKLMNOPQRSTUVWXYZ", "0123456789", " ", "\n"};
      test_reset();
      test_latency();
      test_mapping_sweep();
      test_backpressure();
      test_full_push_pop();
      test_clr();
      test_srst_midstream();
      test_long_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
